pipe_shifter: RTL and testbench
===============================

# pipe_shifter

Parametrised, pipelined barrel shifter for the execute stage: a successor to the 16-bit combinational SLL/SRA shifter, generalised to any power-of-two `WIDTH` and four shift modes. One log2 stage per pipeline register gives a valid/ready streaming unit that sustains one operation per cycle, with backpressure, flush and a passthrough tag for the destination register.

## Interface
Parameters:
- `WIDTH`, 16: data width; power of two, ≥ 4.
- `TAG_W`, 4: width of the opaque tag carried alongside the data.
- `SHAMT_W`, `$clog2(WIDTH)`: derived shift-amount width; not overridden.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline clear.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  unit accepts input this cycle.
- `in_data`  in  WIDTH  operand.
- `in_shamt`  in  SHAMT_W  shift amount, 0..WIDTH-1.
- `in_mode`  in  2  00 SLL, 01 SRA, 10 ROR, 11 SRL.
- `in_tag`  in  TAG_W  passthrough tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  WIDTH  shifted result.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- The shift is decomposed into `SHAMT_W` stages.
- Stage k shifts by 2^k when `shamt[k]` = 1; otherwise it passes the data through.
- Each stage's output is registered together with its valid bit, mode, remaining shamt bits and tag.
- Mode semantics:
  - SLL: zero fill from the LSB.
  - SRA: fill with the current stage's MSB, which is the original sign because earlier stages preserve it.
  - SRL: zero fill from the MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Shift by 0 returns `in_data` unchanged in every mode.
- Global advance enable `adv = out_ready | ~out_valid`.
  - `in_ready = adv`.
  - When `adv` = 0, every stage register holds its value.
- Bubbles are not collapsed: an invalid stage still occupies its slot and advances only with `adv`.
- Input is accepted on `in_valid & in_ready`.
- `flush` clears every stage valid bit the same cycle. Data registers may hold stale contents.
  - An input presented in the same cycle as `flush` is dropped.
  - `flush` takes priority over a stall.
- `rst` clears all valid bits and all data, mode, tag and shamt registers to 0.
  - `out_valid`, `out_data` and `out_tag` reset to 0.
  - `rst` mid-operation discards all in-flight operations.
- Mode bit and shamt fields are consumed per stage. Widths are exact; there is no overflow or carry output.

## Timing
- Latency is `SHAMT_W` cycles from acceptance to `out_valid` (4 for WIDTH=16).
- Throughput: 1 operation per cycle while `out_ready` = 1.
- `in_ready` is combinational from `out_ready` and `out_valid`. There is no combinational path from `in_*` to `out_*`.
- With `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_tag` stay stable until the handshake completes.
- A handshake in cycle N presents the next queued result in cycle N+1.
- Back-to-back operations with mixed modes produce results in order.

## Configuration
- Macro: `PIPE_SHIFTER_ROR_EN`.
- Defined: mode 10 performs a rotate right.
- Undefined:
  - No rotate wrap logic is built.
  - Mode 10 passes the operand through unshifted.
  - Tag and latency are unaffected.

## Structure
- Package `shifter_pkg` holds:
  - `typedef enum logic [1:0] shift_mode_e` with `SH_SLL`, `SH_SRA`, `SH_ROR`, `SH_SRL`.
  - The mode-encoding constants.
- Sub-module `shift_stage`:
  - Combinational, parametrised by `WIDTH` and `DIST`.
  - Implements a single 2^k step for all modes.
  - Instantiated `SHAMT_W` times in a generate loop, each followed by the stage register in the top level.

## Test plan
- SRA, WIDTH=16, 0x8000 by 15 → 0xFFFF, valid exactly 4 cycles after acceptance; SRL of the same → 0x0001.
- SLL 0x0001 by 4 → 0x0010; by 0 → 0x0001; tags 3 and 5 return with their results.
- ROR 0x1234 by 4 → 0x4123 with the macro defined. Without it, the same stimulus → 0x1234.
- Stream 8 operations, hold `out_ready` = 0 for 3 cycles mid-stream:
  - `out_data` is stable during the stall.
  - `in_ready` = 0 during the stall.
  - All 8 results arrive in order with none lost or duplicated.
- Assert `flush` with 3 operations in flight and `in_valid` = 1 → no `out_valid` for the next 4 cycles. The next accepted operation completes normally.
- Assert `rst` mid-stream → all outputs 0 the next cycle and the in-flight results never appear. Repeat with WIDTH=32: SRA 0x80000000 by 31 → 0xFFFFFFFF after 5 cycles.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Contents: shift-mode encodings and the shift_mode_e enum carried
// through every pipeline stage.
package shifter_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_SLL = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SRA = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ROR = 2'b10;
  localparam logic [MODE_W-1:0] MODE_SRL = 2'b11;

  typedef enum logic [MODE_W-1:0] {
    SH_SLL = MODE_SLL,
    SH_SRA = MODE_SRA,
    SH_ROR = MODE_ROR,
    SH_SRL = MODE_SRL
  } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One log2 step of the barrel shifter: shifts by DIST when en is set,
// otherwise passes data through. Purely combinational.
// Ports:
//   data     operand from the previous stage
//   mode     shift mode (SLL / SRA / ROR / SRL)
//   en       this stage's shift-amount bit
//   result_c shifted operand
// Build option: PIPE_SHIFTER_ROR_EN builds the rotate wrap; without it
// mode ROR passes the operand unchanged.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_e      mode,
  input  logic             en,
  output logic [WIDTH-1:0] result_c
);

  // Single-step shift for every mode; SRA replicates this stage's MSB,
  // which earlier stages have kept equal to the original sign.
  always_comb begin
    result_c = data;
    if (en) begin
      case (mode)
        SH_SLL:  result_c = data << DIST;
        SH_SRA:  result_c = WIDTH'($signed(data) >>> DIST);
        SH_SRL:  result_c = data >> DIST;
`ifdef PIPE_SHIFTER_ROR_EN
        SH_ROR:  result_c = {data[DIST-1:0], data[WIDTH-1:DIST]};
`else
        SH_ROR:  result_c = data;
`endif
        default: result_c = data;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined valid/ready barrel shifter: one log2 shift step per register
// stage, SHAMT_W stages of latency, one operation per cycle throughput.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           clears all in-flight operations (same-cycle input dropped)
//   in_valid/ready  input handshake; in_ready is combinational from output side
//   in_data/shamt/mode/tag  operand, shift amount, mode, passthrough tag
//   out_valid/ready output handshake
//   out_data/tag    result and its tag (registered)
// Build option: PIPE_SHIFTER_ROR_EN enables rotate-right for mode 2'b10.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned NSTG = SHAMT_W;

  logic               valid_q [NSTG];
  logic [WIDTH-1:0]   data_q  [NSTG];
  shift_mode_e        mode_q  [NSTG];
  logic [SHAMT_W-1:0] shamt_q [NSTG];
  logic [TAG_W-1:0]   tag_q   [NSTG];

  logic [WIDTH-1:0]   shifted_c [NSTG];
  logic               adv_c;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c;

  // Stage k shifts by 2^k under shamt bit k, fed by the previous register.
  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_head
      shift_stage #(.WIDTH(WIDTH), .DIST(1)) u_stage (
        .data     (in_data),
        .mode     (shift_mode_e'(in_mode)),
        .en       (in_shamt[0]),
        .result_c (shifted_c[0])
      );
    end else begin : g_body
      shift_stage #(.WIDTH(WIDTH), .DIST(2 ** k)) u_stage (
        .data     (data_q[k-1]),
        .mode     (mode_q[k-1]),
        .en       (shamt_q[k-1][k]),
        .result_c (shifted_c[k])
      );
    end
  end

  // Stage registers; bubbles advance in place, flush wins over a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        mode_q[k]  <= SH_SLL;
        shamt_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      if (adv_c) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= shifted_c[0];
        mode_q[0]  <= shift_mode_e'(in_mode);
        shamt_q[0] <= in_shamt;
        tag_q[0]   <= in_tag;
        for (int unsigned k = 1; k < NSTG; k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= shifted_c[k];
          mode_q[k]  <= mode_q[k-1];
          shamt_q[k] <= shamt_q[k-1];
          tag_q[k]   <= tag_q[k-1];
        end
      end
      if (flush) begin
        for (int unsigned k = 0; k < NSTG; k++) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q[NSTG-1];
  assign out_data  = data_q[NSTG-1];
  assign out_tag   = tag_q[NSTG-1];

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_shamt, in_tag, out_tag;
  logic [1:0]  in_mode;

  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_data, w_out_data;
  logic [4:0]  w_in_shamt;
  logic [1:0]  w_in_mode;
  logic [3:0]  w_in_tag, w_out_tag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  pipe_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_shamt(w_in_shamt), .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_tag(w_out_tag)
  );

  // Issue one operation into an idle pipe and collect its result and latency.
  task automatic run_op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] s,
                        input logic [3:0] t, output logic [15:0] rd, output logic [3:0] rt,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = s; in_tag = t; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = out_data;
    rt = out_tag;
  endtask

  task automatic run_op32(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s,
                          input logic [3:0] t, output logic [31:0] rd, output logic [3:0] rt,
                          output int lat);
    @(negedge clk);
    w_in_valid = 1'b1; w_in_mode = m; w_in_data = d; w_in_shamt = s; w_in_tag = t;
    w_out_ready = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = w_out_data;
    rt = w_out_tag;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_data = '0; w_in_shamt = '0; w_in_mode = '0; w_in_tag = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++;
    if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data got %h exp 0000", out_data); end
    vectors++;
    if (out_tag !== 4'h0) begin miscompares++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++;
    if (w_out_valid !== 1'b0 || w_out_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_w32 got valid %b data %h exp 0/0", w_out_valid, w_out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_sra_srl;
    logic [15:0] rd; logic [3:0] rt; int lat;
    run_op(2'b01, 16'h8000, 4'd15, 4'd1, rd, rt, lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL sra_latency got %0d exp 4", lat); end
    vectors++;
    if (rd !== 16'hFFFF) begin miscompares++; $display("FAIL sra_data got %h exp FFFF", rd); end
    vectors++;
    if (rt !== 4'd1) begin miscompares++; $display("FAIL sra_tag got %0d exp 1", rt); end
    run_op(2'b11, 16'h8000, 4'd15, 4'd2, rd, rt, lat);
    vectors++;
    if (rd !== 16'h0001) begin miscompares++; $display("FAIL srl_data got %h exp 0001", rd); end
    run_op(2'b01, 16'h4000, 4'd3, 4'd2, rd, rt, lat);
    vectors++;
    if (rd !== 16'h0800) begin miscompares++; $display("FAIL sra_pos_data got %h exp 0800", rd); end
  endtask

  task automatic test_sll;
    logic [15:0] rd; logic [3:0] rt; int lat;
    run_op(2'b00, 16'h0001, 4'd4, 4'd3, rd, rt, lat);
    vectors++;
    if (rd !== 16'h0010) begin miscompares++; $display("FAIL sll4_data got %h exp 0010", rd); end
    vectors++;
    if (rt !== 4'd3) begin miscompares++; $display("FAIL sll4_tag got %0d exp 3", rt); end
    run_op(2'b00, 16'h0001, 4'd0, 4'd5, rd, rt, lat);
    vectors++;
    if (rd !== 16'h0001) begin miscompares++; $display("FAIL sll0_data got %h exp 0001", rd); end
    vectors++;
    if (rt !== 4'd5) begin miscompares++; $display("FAIL sll0_tag got %0d exp 5", rt); end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL sll0_latency got %0d exp 4", lat); end
    run_op(2'b01, 16'h9234, 4'd0, 4'd6, rd, rt, lat);
    vectors++;
    if (rd !== 16'h9234) begin miscompares++; $display("FAIL sra0_data got %h exp 9234", rd); end
  endtask

  task automatic test_ror;
    logic [15:0] rd; logic [3:0] rt; logic [15:0] exp1, exp2; int lat;
`ifdef PIPE_SHIFTER_ROR_EN
    exp1 = 16'h4123; exp2 = 16'h8000;
`else
    exp1 = 16'h1234; exp2 = 16'h0001;
`endif
    run_op(2'b10, 16'h1234, 4'd4, 4'd7, rd, rt, lat);
    vectors++;
    if (rd !== exp1) begin miscompares++; $display("FAIL ror4_data got %h exp %h", rd, exp1); end
    vectors++;
    if (rt !== 4'd7 || lat !== 4) begin
      miscompares++; $display("FAIL ror4_tag_lat got %0d/%0d exp 7/4", rt, lat);
    end
    run_op(2'b10, 16'h0001, 4'd1, 4'd8, rd, rt, lat);
    vectors++;
    if (rd !== exp2) begin miscompares++; $display("FAIL ror1_data got %h exp %h", rd, exp2); end
    run_op(2'b10, 16'hBEEF, 4'd0, 4'd8, rd, rt, lat);
    vectors++;
    if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL ror0_data got %h exp BEEF", rd); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  m [8];
    logic [15:0] d [8];
    logic [3:0]  s [8];
    logic [15:0] e [8];
    logic [15:0] held;
    int issued, recvd;
    m[0] = 2'b00; d[0] = 16'h00F0; s[0] = 4'd4;  e[0] = 16'h0F00;
    m[1] = 2'b11; d[1] = 16'hF000; s[1] = 4'd8;  e[1] = 16'h00F0;
    m[2] = 2'b01; d[2] = 16'hF000; s[2] = 4'd8;  e[2] = 16'hFFF0;
    m[3] = 2'b01; d[3] = 16'h7000; s[3] = 4'd12; e[3] = 16'h0007;
    m[4] = 2'b00; d[4] = 16'h8001; s[4] = 4'd1;  e[4] = 16'h0002;
    m[5] = 2'b10; d[5] = 16'h00FF; s[5] = 4'd8;
`ifdef PIPE_SHIFTER_ROR_EN
    e[5] = 16'hFF00;
`else
    e[5] = 16'h00FF;
`endif
    m[6] = 2'b11; d[6] = 16'hABCD; s[6] = 4'd4;  e[6] = 16'h0ABC;
    m[7] = 2'b00; d[7] = 16'hABCD; s[7] = 4'd15; e[7] = 16'h8000;
    issued = 0; recvd = 0; held = '0;
    for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid = (issued < 8);
      if (issued < 8) begin
        in_mode = m[issued]; in_data = d[issued]; in_shamt = s[issued]; in_tag = 4'(issued);
      end
      #1;
      if (!out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", cyc, in_ready); end
        if (cyc > 6) begin
          vectors++;
          if (out_data !== held) begin miscompares++; $display("FAIL stall_stable cyc %0d got %h exp %h", cyc, out_data, held); end
        end
        held = out_data;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (recvd >= 8) begin
          miscompares++; $display("FAIL stream_extra got tag %0d exp none", out_tag);
        end else if (out_data !== e[recvd] || out_tag !== 4'(recvd)) begin
          miscompares++;
          $display("FAIL stream_result %0d got %h/%0d exp %h/%0d", recvd, out_data, out_tag, e[recvd], recvd);
        end
        recvd++;
      end
      if (in_valid && in_ready) issued++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (recvd != 8) begin miscompares++; $display("FAIL stream_count got %0d exp 8", recvd); end
  endtask

  task automatic test_flush;
    logic [15:0] rd; logic [3:0] rt; int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h0001; in_shamt = 4'(i + 1); in_tag = 4'(9 + i);
      out_ready = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0003; in_tag = 4'd12;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_quiet cyc %0d got %b exp 0", i, out_valid); end
      @(negedge clk);
    end
    run_op(2'b11, 16'h0F00, 4'd8, 4'd6, rd, rt, lat);
    vectors++;
    if (rd !== 16'h000F || rt !== 4'd6 || lat !== 4) begin
      miscompares++; $display("FAIL flush_next got %h/%0d/%0d exp 000F/6/4", rd, rt, lat);
    end
  endtask

  task automatic test_rst_midstream;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h00AA; in_shamt = 4'd2; in_tag = 4'hE; out_ready = 1'b1;
    @(negedge clk);
    in_data = 16'h00BB; in_tag = 4'hF;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got %b/%h/%h exp 0/0000/0", out_valid, out_data, out_tag);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL rst_mid_ghost got %0d results exp 0", seen); end
  endtask

  task automatic test_width32;
    logic [31:0] rd; logic [3:0] rt; int lat;
    run_op32(2'b01, 32'h8000_0000, 5'd31, 4'd2, rd, rt, lat);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL w32_sra_data got %h exp FFFFFFFF", rd); end
    vectors++;
    if (lat !== 5 || rt !== 4'd2) begin miscompares++; $display("FAIL w32_sra_lat_tag got %0d/%0d exp 5/2", lat, rt); end
    run_op32(2'b00, 32'h0000_0001, 5'd31, 4'd4, rd, rt, lat);
    vectors++;
    if (rd !== 32'h8000_0000) begin miscompares++; $display("FAIL w32_sll_data got %h exp 80000000", rd); end
  endtask

  initial begin
    test_reset();
    test_sra_srl();
    test_sll();
    test_ror();
    test_back_to_back();
    test_flush();
    test_rst_midstream();
    test_width32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
